// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
//   Serial bit-pattern transmitter. On an accepted start it latches a PAT_W-bit
//   pattern and a repeat count, then shifts the pattern out MSB-first, one bit
//   per clock, for the requested number of repetitions. A one-cycle FIN state
//   pulses done before returning to IDLE. Intended as the stimulus source for
//   serial sequence detectors (dout feeds the detector's din directly).
//
// Optional feature macro: GAP_INSERT_EN
//   When defined, a single GAP cycle (no valid bit, busy held) separates
//   consecutive repetitions. When undefined, repetitions are contiguous and the
//   GAP state does not exist.
//
// Parameters
//   PAT_W        pattern width in bits (>= 2)
//   CNT_W        repeat-count width; max repetitions = 2**CNT_W-1
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high
//   start        in   1      request; accepted only in IDLE
//   pat_in       in   PAT_W  pattern, sampled when start is accepted
//   rep_in       in   CNT_W  repetitions, sampled when start is accepted
//   dout         out  1      serial data bit (0 when dout_valid=0)
//   dout_valid   out  1      dout carries a pattern bit this cycle
//   frame_start  out  1      high with the first (MSB) bit of each repetition
//   busy         out  1      high from the cycle after acceptance through FIN
//   done         out  1      one-cycle pulse after the last bit
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int              IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef GAP_INSERT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_FIN   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd3
    } state_t;
`endif

    state_t             state_r, state_s;
    logic [PAT_W-1:0]   shreg_r, shreg_s;
    logic [IDX_W-1:0]   bit_idx_r, bit_idx_s;
    logic [CNT_W-1:0]   rep_cnt_r, rep_cnt_s;
    logic [CNT_W-1:0]   rep_dec_s;

    logic               dout_r, dout_valid_r, frame_start_r, busy_r, done_r;
    logic               dout_s, dout_valid_s, frame_start_s, busy_s, done_s;

    // Saturating decrement of the repetition counter so it can never wrap.
    always_comb begin
        rep_dec_s = CNT_ZERO;
        if (rep_cnt_r != CNT_ZERO) begin
            rep_dec_s = rep_cnt_r - CNT_ONE;
        end else begin
            rep_dec_s = CNT_ZERO;
        end
    end

    // Next-state, shift register, bit index and repetition counter.
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        bit_idx_s = bit_idx_r;
        rep_cnt_s = rep_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    shreg_s   = pat_in;
                    rep_cnt_s = rep_in;
                    bit_idx_s = IDX_MAX;
                    if (rep_in != CNT_ZERO) begin
                        state_s = ST_SHIFT;
                    end else begin
                        state_s = ST_FIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_idx_r == IDX_ZERO) begin
                    // Last bit of this repetition: the pattern stays in shreg
                    // and is replayed from the MSB, pat_in is not re-read.
                    rep_cnt_s = rep_dec_s;
                    bit_idx_s = IDX_MAX;
                    if (rep_dec_s == CNT_ZERO) begin
                        state_s = ST_FIN;
                    end else begin
`ifdef GAP_INSERT_EN
                        state_s = ST_GAP;
`else
                        state_s = ST_SHIFT;
`endif
                    end
                end else begin
                    bit_idx_s = bit_idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
`ifdef GAP_INSERT_EN
            ST_GAP: begin
                state_s = ST_SHIFT;
            end
`endif
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values derived from the upcoming state so that the registered
    // outputs line up with the state they describe.
    always_comb begin
        dout_s        = 1'b0;
        dout_valid_s  = 1'b0;
        frame_start_s = 1'b0;
        busy_s        = 1'b0;
        done_s        = 1'b0;
        case (state_s)
            ST_SHIFT: begin
                dout_s        = shreg_s[bit_idx_s];
                dout_valid_s  = 1'b1;
                frame_start_s = (bit_idx_s == IDX_MAX);
                busy_s        = 1'b1;
            end
`ifdef GAP_INSERT_EN
            ST_GAP: begin
                busy_s = 1'b1;
            end
`endif
            ST_FIN: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            shreg_r       <= {PAT_W{1'b0}};
            bit_idx_r     <= IDX_ZERO;
            rep_cnt_r     <= CNT_ZERO;
            dout_r        <= 1'b0;
            dout_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            shreg_r       <= shreg_s;
            bit_idx_r     <= bit_idx_s;
            rep_cnt_r     <= rep_cnt_s;
            dout_r        <= dout_s;
            dout_valid_r  <= dout_valid_s;
            frame_start_r <= frame_start_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    assign dout        = dout_r;
    assign dout_valid  = dout_valid_r;
    assign frame_start = frame_start_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_gen
//   Directed, self-checking bench for seq_pattern_gen (default build, no gaps).
//   A PAT_W=4 instance covers the table-driven cases and the reset-abort
//   sequence; a PAT_W=8 instance covers the full-count 255-repetition frame.
//   Output vectors are packed as {dout, dout_valid, frame_start, busy, done}.
// -----------------------------------------------------------------------------
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] pat_in;
    logic [7:0] rep_in;
    logic       dout, dout_valid, frame_start, busy, done;

    logic       reset8, start8;
    logic [7:0] pat8, rep8;
    logic       dout8, dout_valid8, frame_start8, busy8, done8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_pattern_gen #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .pat_in(pat_in), .rep_in(rep_in),
        .dout(dout), .dout_valid(dout_valid), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    seq_pattern_gen #(.PAT_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .pat_in(pat8), .rep_in(rep8),
        .dout(dout8), .dout_valid(dout_valid8), .frame_start(frame_start8),
        .busy(busy8), .done(done8)
    );

    wire [4:0] outs4 = {dout, dout_valid, frame_start, busy, done};
    wire [4:0] outs8 = {dout8, dout_valid8, frame_start8, busy8, done8};

    typedef struct {
        logic       start;
        logic [3:0] pat;
        logic [7:0] rep;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] p8;
        logic [3:0] det;
        int         hits;
        int         bad;
        int         nvalid;
        logic [4:0] e;

        // Test 1: 1010 x1. Entry i is applied before edge i, checked in cycle i+1.
        vecs[0]  = '{1'b1, 4'b1010, 8'd1, 5'b11110};
        vecs[1]  = '{1'b0, 4'b1010, 8'd1, 5'b01010};
        vecs[2]  = '{1'b0, 4'b1010, 8'd1, 5'b11010};
        vecs[3]  = '{1'b0, 4'b1010, 8'd1, 5'b01010};
        vecs[4]  = '{1'b0, 4'b1010, 8'd1, 5'b00011};
        vecs[5]  = '{1'b0, 4'b1010, 8'd1, 5'b00000};
        // Test 4: same frame with start requests while busy, which are ignored.
        vecs[6]  = '{1'b1, 4'b1010, 8'd1, 5'b11110};
        vecs[7]  = '{1'b0, 4'b1010, 8'd1, 5'b01010};
        vecs[8]  = '{1'b1, 4'b1111, 8'd5, 5'b11010};
        vecs[9]  = '{1'b0, 4'b1111, 8'd5, 5'b01010};
        vecs[10] = '{1'b1, 4'b1111, 8'd5, 5'b00011};
        vecs[11] = '{1'b0, 4'b1111, 8'd5, 5'b00000};
        // Test 3: rep=0 goes straight to FIN.
        vecs[12] = '{1'b1, 4'b1111, 8'd0, 5'b00011};
        vecs[13] = '{1'b0, 4'b1111, 8'd0, 5'b00000};

        reset = 1'b1; start = 1'b0; pat_in = 4'd0; rep_in = 8'd0;
        reset8 = 1'b1; start8 = 1'b0; pat8 = 8'd0; rep8 = 8'd0;
        step();
        step();
        chk("reset_outs4", {27'd0, outs4}, 32'd0);
        chk("reset_outs8", {27'd0, outs8}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            start  = vecs[i].start;
            pat_in = vecs[i].pat;
            rep_in = vecs[i].rep;
            step();
            chk($sformatf("vec%0d", i), {27'd0, outs4}, {27'd0, vecs[i].exp});
        end
        start = 1'b0;

        // Test 2: 1010 x3, contiguous, feeding an overlapping 1010 detector.
        start = 1'b1; pat_in = 4'b1010; rep_in = 8'd3;
        step();
        start = 1'b0; pat_in = 4'b0000; rep_in = 8'd9;
        det = 4'd0; hits = 0;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 12) e = {(c % 2 == 1) ? 1'b1 : 1'b0, 1'b1, (c % 4 == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            else         e = 5'b00011;
            chk($sformatf("t2_c%0d", c), {27'd0, outs4}, {27'd0, e});
            if (dout_valid) begin
                det = {det[2:0], dout};
                if (det == 4'b1010) hits++;
            end
            step();
        end
        chk("t2_hits", hits, 32'd5);
        chk("t2_idle", {27'd0, outs4}, 32'd0);

        // Test 5: reset during a rep=2 frame, then a fresh start.
        start = 1'b1; pat_in = 4'b1010; rep_in = 8'd2;
        step();                                   // cycle 1
        start = 1'b0;
        chk("t5_c1", {27'd0, outs4}, {27'd0, 5'b11110});
        step();                                   // cycle 2
        step();                                   // cycle 3
        reset = 1'b1;
        step();                                   // cycle 4
        chk("t5_c4_abort", {27'd0, outs4}, 32'd0);
        reset = 1'b0;
        step();                                   // cycle 5
        chk("t5_c5_nodone", {27'd0, outs4}, 32'd0);
        start = 1'b1; pat_in = 4'b1100; rep_in = 8'd1;
        step();                                   // cycle 6
        start = 1'b0;
        chk("t5_c6_first", {27'd0, outs4}, {27'd0, 5'b11110});
        step(); step(); step();                   // cycles 7..9
        step();                                   // cycle 10
        chk("t5_c10_done", {27'd0, outs4}, {27'd0, 5'b00011});

        // Test 6: PAT_W=8, 255 repetitions of A5 with start held high.
        reset8 = 1'b0;
        p8 = 8'hA5;
        start8 = 1'b1; pat8 = p8; rep8 = 8'hFF;
        step();                                   // cycle 1
        pat8 = 8'h00; rep8 = 8'h01;
        bad = 0; nvalid = 0;
        for (int c = 1; c <= 2040; c++) begin
            e = {p8[7 - ((c - 1) % 8)], 1'b1, ((c - 1) % 8 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            if (dout_valid8) nvalid++;
            if (outs8 !== e) begin
                if (bad < 4) $display("FAIL t6_stream cycle=%0d actual=%0h required=%0h", c, outs8, e);
                bad++;
            end
            step();
        end
        chk("t6_stream_bad", bad, 32'd0);
        chk("t6_valid_count", nvalid, 32'd2040);
        chk("t6_c2041_done", {27'd0, outs8}, {27'd0, 5'b00011});
        step();
        chk("t6_c2042_idle", {27'd0, outs8}, 32'd0);
        pat8 = 8'h80;
        step();
        chk("t6_c2043_next", {27'd0, outs8}, {27'd0, 5'b11110});
        reset8 = 1'b1; start8 = 1'b0;
        step();
        chk("t6_reset_abort", {27'd0, outs8}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
